bp_me_cce_mem_cmd_arbiter: RTL
==============================

# bp_me_cce_mem_cmd_arbiter

Round-robin arbiter that shares the single CCE-to-memory BedRock burst command channel (header + data streams, ready&valid) among `num_src_p` CCE-side requesters, e.g. the coherent pipe, the uncached pipe and the writeback pipe. A granted message owns the channel from header acceptance through its last data beat, so bursts from different sources never interleave. The block also reports grant state and per-burst beat counts for the nonsynth tracers, and flags overlong bursts.

## Interface
- `num_src_p`, 3: number of requesters (2..8).
- `header_width_p`, `cce_mem_msg_header_width_lp`: header bits per source.
- `data_width_p`, `dword_width_gp` (64): data beat bits.
- `max_beats_p`, 8: legal beats per burst; the counter is `$clog2(max_beats_p+1)` bits wide.

Ports:
- `clk_i` in 1: clock, posedge.
- `reset_i` in 1: reset, asynchronous, active-low.
- `src_header_i` in `num_src_p*header_width_p`: packed headers, source 0 in the LSBs.
- `src_header_v_i` in `num_src_p`: header valid.
- `src_has_data_i` in `num_src_p`: message carries a data burst; qualified by header valid.
- `src_header_ready_and_o` out `num_src_p`.
- `src_data_i` in `num_src_p*data_width_p`, `src_data_v_i` in `num_src_p`, `src_data_last_i` in `num_src_p`, `src_data_ready_and_o` out `num_src_p`.
- `mem_cmd_header_o` out `header_width_p`, `mem_cmd_header_v_o` out 1, `mem_cmd_header_ready_and_i` in 1.
- `mem_cmd_data_o` out `data_width_p`, `mem_cmd_data_v_o` out 1, `mem_cmd_data_last_o` out 1, `mem_cmd_data_ready_and_i` in 1.
- `grant_o` out `num_src_p`: one-hot owner. All zero when there is no owner.
- `beat_cnt_o` out counter width: beats accepted in the current burst.
- `overrun_o` out 1: sticky error flag.

## Operation
- State machine `e_idle`, `e_hdr_hold`, `e_data`.
- Round-robin pointer `rr_r` holds the highest-priority source index.
- **`e_idle`**
  - Winner = first source with `src_header_v_i` set, scanning from `rr_r` upward with wrap.
  - Drive the winner's header combinationally: `mem_cmd_header_v_o=1`, `grant_o`=winner, and the winner's `src_header_ready_and_o` = `mem_cmd_header_ready_and_i`. All other ready outputs are 0.
  - Header handshake with `has_data=1`: latch the owner, go to `e_data`, clear `beat_cnt`.
  - Header handshake with `has_data=0`: set `rr_r` = winner+1 (mod `num_src_p`) and stay in `e_idle`.
  - Valid but not ready: latch the owner and go to `e_hdr_hold`.
- **`e_hdr_hold`**
  - Present the latched owner's header; no re-arbitration, so the header stays stable under backpressure.
  - On handshake, branch exactly as in `e_idle`.
- **`e_data`**
  - Steer the owner's data, valid and last to the output; the owner's data ready = `mem_cmd_data_ready_and_i`.
  - All header readies are 0.
  - Each data handshake increments `beat_cnt`.
  - Handshake with last=1: `rr_r` = owner+1 and go to `e_idle`.
- **Overrun**
  - A handshake that would take `beat_cnt` past `max_beats_p` sets `overrun_o`.
  - The sticky flag clears only on reset. Forwarding continues.
- **Arithmetic**
  - `rr_r` wraps modulo `num_src_p`. It is not a power-of-two mask.
  - `beat_cnt` saturates at its maximum value.
- **Source-side rules**
  - A source dropping valid before its handshake is a protocol violation; assert in simulation.
  - Data from non-owners is never consumed.

## Timing
- **Reset** (`reset_i`=0, asynchronous): state=`e_idle`, `rr_r`=0, owner=0, `beat_cnt_o`=0, `overrun_o`=0.
  - While in reset, all valid, ready and grant outputs are 0.
  - Deasserting reset mid-burst discards the burst; no partial burst resumes.
- Header path has 0-cycle latency (combinational mux). Data path has 0-cycle latency.
- Headerless messages can issue one per cycle, rotating among sources.
- First data beat can transfer no earlier than the cycle after header acceptance. Data presented in the header cycle waits.
- After the last beat at cycle N, the next header can be accepted at N+1.
- A single source that is always valid still receives back-to-back grants when it is the only requester.
- A source raising valid in the same cycle the pointer advances is arbitrated against the new `rr_r`.

## Test plan
- **Reset:** assert reset with all sources valid → all outputs 0. Release reset with only source 0 valid and `has_data=0` → `grant_o`=001 and a header handshake in the same cycle.
- **Rotation:** sources 0,1,2 continuously valid, `has_data=0`, ready=1 → grants 001, 010, 100, 001 on consecutive cycles.
- **Burst lock:** source 1 sends a 4-beat burst while sources 0 and 2 are valid → `grant_o`=010 for header plus 4 beats, `beat_cnt_o` reaches 4, then source 2 is granted next.
- **Backpressure:** ready=0 for 3 cycles while source 0 is presented, then source 2 becomes valid → header and grant unchanged (`e_hdr_hold`), source 0 is accepted on cycle 4.
- **Overrun:** `max_beats_p`=8, source sends 9 beats with last on beat 9 → `overrun_o`=1 after the 9th handshake and stays 1. All 9 beats are forwarded.
- **Mid-burst reset:** assert reset during beat 2 of 4 → outputs 0 asynchronously. After release, the first grant goes to source 0 by priority.

Source files
------------

// File: rtl/bp_me_cce_mem_cmd_arbiter.sv
// Round-robin arbiter sharing one BedRock mem command channel (header + burst data)
// among CCE-side sources; a grant is held from header acceptance to the last data beat.
module bp_me_cce_mem_cmd_arbiter #(
   parameter int unsigned num_src_p      = 3,
   parameter int unsigned header_width_p = 64,
   parameter int unsigned data_width_p   = 64,
   parameter int unsigned max_beats_p    = 8,
   localparam int unsigned cnt_w_lp      = $clog2(max_beats_p + 1)
) (
   input  logic                                clk_i,
   input  logic                                reset_i,
   input  logic [num_src_p*header_width_p-1:0] src_header_i,
   input  logic [num_src_p-1:0]                src_header_v_i,
   input  logic [num_src_p-1:0]                src_has_data_i,
   output logic [num_src_p-1:0]                src_header_ready_and_o,
   input  logic [num_src_p*data_width_p-1:0]   src_data_i,
   input  logic [num_src_p-1:0]                src_data_v_i,
   input  logic [num_src_p-1:0]                src_data_last_i,
   output logic [num_src_p-1:0]                src_data_ready_and_o,
   output logic [header_width_p-1:0]           mem_cmd_header_o,
   output logic                                mem_cmd_header_v_o,
   input  logic                                mem_cmd_header_ready_and_i,
   output logic [data_width_p-1:0]             mem_cmd_data_o,
   output logic                                mem_cmd_data_v_o,
   output logic                                mem_cmd_data_last_o,
   input  logic                                mem_cmd_data_ready_and_i,
   output logic [num_src_p-1:0]                grant_o,
   output logic [cnt_w_lp-1:0]                 beat_cnt_o,
   output logic                                overrun_o
);
   localparam int unsigned src_w_lp = (num_src_p > 1) ? $clog2(num_src_p) : 1;

   typedef enum logic [1:0] {e_idle, e_hdr_hold, e_data} state_e;

   state_e              state_q, state_d;
   logic [src_w_lp-1:0] rr_q, rr_d;
   logic [src_w_lp-1:0] owner_q, owner_d;
   logic [cnt_w_lp-1:0] beat_cnt_q, beat_cnt_d;
   logic                overrun_q, overrun_d;

   logic                win_v;
   logic [src_w_lp-1:0] win;
   int unsigned         scan;
   logic [src_w_lp-1:0] hdr_src;
   logic                hdr_v;
   logic                hdr_hs;
   logic                data_v;
   logic                data_hs;

   function automatic logic [src_w_lp-1:0] next_src(input logic [src_w_lp-1:0] s);
      return (32'(s) == num_src_p - 1) ? '0 : s + src_w_lp'(1);
   endfunction

   // First valid header scanning upward from rr_q; the index wraps modulo num_src_p
   always_comb begin
      win_v = 1'b0;
      win   = rr_q;
      scan  = 0;
      for (int unsigned i = 0; i < num_src_p; i++) begin
         scan = 32'(rr_q) + i;
         if (scan >= num_src_p) scan = scan - num_src_p;
         if (!win_v && src_header_v_i[src_w_lp'(scan)]) begin
            win_v = 1'b1;
            win   = src_w_lp'(scan);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      rr_d       = rr_q;
      owner_d    = owner_q;
      beat_cnt_d = beat_cnt_q;
      overrun_d  = overrun_q;

      hdr_src = (state_q == e_hdr_hold) ? owner_q : win;
      hdr_v   = 1'b0;
      hdr_hs  = 1'b0;
      data_v  = src_data_v_i[owner_q];
      data_hs = 1'b0;

      grant_o                = '0;
      src_header_ready_and_o = '0;
      src_data_ready_and_o   = '0;
      mem_cmd_header_o       = src_header_i[32'(hdr_src)*header_width_p +: header_width_p];
      mem_cmd_header_v_o     = 1'b0;
      mem_cmd_data_o         = src_data_i[32'(owner_q)*data_width_p +: data_width_p];
      mem_cmd_data_v_o       = 1'b0;
      mem_cmd_data_last_o    = 1'b0;

      case (state_q)
         e_idle, e_hdr_hold: begin
            // a held header keeps its owner so it stays stable under backpressure
            hdr_v = (state_q == e_hdr_hold) ? src_header_v_i[owner_q] : win_v;
            if (state_q == e_hdr_hold || win_v) begin
               grant_o[hdr_src]                = 1'b1;
               src_header_ready_and_o[hdr_src] = mem_cmd_header_ready_and_i;
            end
            mem_cmd_header_v_o = hdr_v;
            hdr_hs             = hdr_v && mem_cmd_header_ready_and_i;
            if (hdr_hs) begin
               if (src_has_data_i[hdr_src]) begin
                  owner_d    = hdr_src;
                  beat_cnt_d = '0;
                  state_d    = e_data;
               end else begin
                  rr_d    = next_src(hdr_src);
                  state_d = e_idle;
               end
            end else if (hdr_v) begin
               owner_d = hdr_src;
               state_d = e_hdr_hold;
            end
         end
         e_data: begin
            grant_o[owner_q]              = 1'b1;
            src_data_ready_and_o[owner_q] = mem_cmd_data_ready_and_i;
            mem_cmd_data_v_o              = data_v;
            mem_cmd_data_last_o           = src_data_last_i[owner_q];
            data_hs                       = data_v && mem_cmd_data_ready_and_i;
            if (data_hs) begin
               if (32'(beat_cnt_q) >= max_beats_p) overrun_d = 1'b1;
               if (beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + cnt_w_lp'(1);
               if (src_data_last_i[owner_q]) begin
                  rr_d    = next_src(owner_q);
                  state_d = e_idle;
               end
            end
         end
         default: state_d = e_idle;
      endcase

      // handshake outputs are forced quiet for as long as reset is held
      if (!reset_i) begin
         grant_o                = '0;
         src_header_ready_and_o = '0;
         src_data_ready_and_o   = '0;
         mem_cmd_header_v_o     = 1'b0;
         mem_cmd_data_v_o       = 1'b0;
         mem_cmd_data_last_o    = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q    <= e_idle;
         rr_q       <= '0;
         owner_q    <= '0;
         beat_cnt_q <= '0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         owner_q    <= owner_d;
         beat_cnt_q <= beat_cnt_d;
         overrun_q  <= overrun_d;
      end
   end

   assign beat_cnt_o = beat_cnt_q;
   assign overrun_o  = overrun_q;

   // a presented header must stay valid until it is accepted
   a_hdr_held: assert property (@(posedge clk_i) disable iff (!reset_i)
      (state_q == e_hdr_hold) |-> src_header_v_i[owner_q]);

endmodule
